cos_sim_accum_ctrl: RTL and testbench
=====================================

Name: cos_sim_accum_ctrl

Overview:
Front-end accumulation sequencer for the cosine-similarity microprogram. It streams element pairs (a_i, b_i) from an upstream valid/ready source. It accumulates dot(A,B), |A|^2 and |B|^2 into the 8-entry intermediate register file using that file's single write port and combinational src_1 read port. On completion the three sums are resident in fixed registers for the downstream sqrt/divide stage.

Parameters:
DATA_W, 16, signed element width; product is 2*DATA_W = 32 bits
LEN_W, 10, width of vector length field
REG_DOT, 3'd0, reg file index holding dot(A,B)
REG_AA, 3'd1, reg file index holding |A|^2
REG_BB, 3'd2, reg file index holding |B|^2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin new vector; sampled only in IDLE
vec_len  in  LEN_W  element count, captured on accepted start
in_valid  in  1  element pair valid
in_ready  out  1  block can accept element pair
a_data  in  DATA_W  signed element a_i
b_data  in  DATA_W  signed element b_i
rf_wr_en  out  1  reg file write enable
rf_dest_reg  out  3  reg file write address
rf_wr_data  out  32  reg file write data
rf_src_1_addr  out  3  reg file read address 1
rf_src_2_addr  out  3  reg file read address 2; tied 3'd0, reserved for downstream stage
rf_src_1_data  in  32  combinational read data for rf_src_1_addr
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, sums final
err_ovf  out  1  sticky signed-overflow flag, cleared on accepted start

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0. This includes in_ready, rf_wr_en, busy, done, err_ovf, and all address and data outputs. Reset mid-operation aborts the run without further writes. Reg file contents are left untouched.
- FSM states: IDLE, CLEAR, WAIT_IN, ACC_AB, ACC_AA, ACC_BB, DONE.
- IDLE: start=1 latches vec_len into a remaining-count register, clears err_ovf and a_i/b_i holding regs, then goes to CLEAR. start is ignored in all other states.
- CLEAR: 3 cycles. Writes 32'd0 to REG_DOT, REG_AA, REG_BB in that order using a 2-bit counter. Next state is WAIT_IN if count != 0, otherwise DONE.
- WAIT_IN: in_ready=1 only here. When in_valid & in_ready, capture a_data and b_data, then go to ACC_AB. Without in_valid, stay; any number of stall cycles is allowed.
- ACC_AB, ACC_AA, ACC_BB: one cycle each, in that order. Each state performs one read-modify-write:
  - rf_src_1_addr = target register.
  - rf_wr_data = rf_src_1_data + product.
  - rf_dest_reg = target register, rf_wr_en = 1.
  - Products are a*b, a*a and b*b respectively, computed as full signed 32-bit.
- After ACC_BB, decrement count. Go to WAIT_IN if the new count != 0, otherwise DONE.
- Addition: 32-bit two's-complement with wrap. err_ovf is set when both addends have the same sign and the result sign differs. It stays set until the next accepted start.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. At this point the reg file already holds the final sums, because the last write committed at the DONE edge.
- Outputs rf_wr_en and in_ready are combinational from state. rf_src_1_addr equals rf_dest_reg whenever rf_wr_en=1. Outside write cycles rf_wr_en=0 and addresses/data are held at 0.
- Timing: start accepted at cycle 0 → CLEAR cycles 1–3 → first WAIT_IN at cycle 4. With in_valid held high, each element takes 4 cycles, so done is asserted at cycle 4+4*vec_len.
- vec_len=0: three clears, then done at cycle 4; all three registers read 0.
- Max vec_len = 2^LEN_W-1; the counter never wraps below 0.

Test Plan:
1. vec_len=3, A=(1,2,3), B=(4,5,6), in_valid high → done at cycle 16; R0=32, R1=14, R2=77; err_ovf=0.
2. vec_len=0 → done at cycle 4; exactly 3 writes of 0 to R0..R2; in_ready never asserted.
3. Signed data: vec_len=2, A=(-3,2), B=(4,-5) → R0=0xFFFFFFEA (-22), R1=13, R2=41.
4. Backpressure: case 1 with 0, 2 and 5 idle cycles of in_valid=0 between elements → identical sums. in_ready is high only in WAIT_IN, and done is delayed by exactly 7 cycles.
5. Overflow: vec_len=2, A=B=(-32768,-32768) → R1=R2=R0=0x80000000 and err_ovf=1 after done. A new start with case 1 clears err_ovf to 0.
6. Control corner cases:
   - start pulsed during ACC_AA is ignored, and results match case 1.
   - rst asserted during the second element's ACC_AB → next cycle state IDLE, all outputs 0, no further rf writes.
   - A subsequent start yields case-1 results.

Source files
------------

// File: rtl/cos_sim_accum_ctrl_if.sv
// rtl/cos_sim_accum_ctrl_if.sv - element-pair stream interface for the cosine-similarity accumulator
interface cos_sim_accum_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;

    modport master (output in_valid, output a_data, output b_data, input in_ready);
    modport slave  (input in_valid, input a_data, input b_data, output in_ready);
endinterface

// File: rtl/cos_sim_accum_ctrl.sv
// rtl/cos_sim_accum_ctrl.sv - accumulates dot(A,B), |A|^2 and |B|^2 into the intermediate register file
module cos_sim_accum_ctrl #(
    parameter int         DATA_W  = 16,
    parameter int         LEN_W   = 10,
    parameter logic [2:0] REG_DOT = 3'd0,
    parameter logic [2:0] REG_AA  = 3'd1,
    parameter logic [2:0] REG_BB  = 3'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     vec_len,
    cos_sim_accum_ctrl_if.slave  in_if,
    output logic                 rf_wr_en,
    output logic [2:0]           rf_dest_reg,
    output logic [31:0]          rf_wr_data,
    output logic [2:0]           rf_src_1_addr,
    output logic [2:0]           rf_src_2_addr,
    input  logic [31:0]          rf_src_1_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err_ovf
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_ACC_AB, S_ACC_AA, S_ACC_BB, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              err_ovf_q, err_ovf_d;

    logic              wr_sel;
    logic              acc_sel;
    logic [2:0]        tgt;
    logic [DATA_W-1:0] op_x, op_y;
    logic [31:0]       prod;
    logic [31:0]       sum;
    logic              ovf;

    function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
        return {{(32-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Write-port and handshake decode from state only, so the read address never depends on read data
    always_comb begin
        wr_sel         = 1'b0;
        acc_sel        = 1'b0;
        tgt            = 3'd0;
        in_if.in_ready = 1'b0;
        case (state_q)
            S_CLEAR: begin
                wr_sel = 1'b1;
                case (clr_cnt_q)
                    2'd0:    tgt = REG_DOT;
                    2'd1:    tgt = REG_AA;
                    default: tgt = REG_BB;
                endcase
            end
            S_WAIT_IN: in_if.in_ready = 1'b1;
            S_ACC_AB: begin
                wr_sel  = 1'b1;
                acc_sel = 1'b1;
                tgt     = REG_DOT;
            end
            S_ACC_AA: begin
                wr_sel  = 1'b1;
                acc_sel = 1'b1;
                tgt     = REG_AA;
            end
            S_ACC_BB: begin
                wr_sel  = 1'b1;
                acc_sel = 1'b1;
                tgt     = REG_BB;
            end
            default: ;
        endcase
    end

    assign rf_wr_en      = wr_sel;
    assign rf_dest_reg   = tgt;
    assign rf_src_1_addr = tgt;
    assign rf_src_2_addr = 3'd0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err_ovf       = err_ovf_q;

    // Read-modify-write datapath: product of the held pair added to the current register value
    always_comb begin
        op_x = '0;
        op_y = '0;
        case (state_q)
            S_ACC_AB: begin op_x = a_q; op_y = b_q; end
            S_ACC_AA: begin op_x = a_q; op_y = a_q; end
            S_ACC_BB: begin op_x = b_q; op_y = b_q; end
            default: ;
        endcase
        prod       = sext(op_x) * sext(op_y);
        sum        = rf_src_1_data + prod;
        ovf        = acc_sel && (rf_src_1_data[31] == prod[31]) && (sum[31] != rf_src_1_data[31]);
        rf_wr_data = acc_sel ? sum : 32'd0;
    end

    // Sequencer next-state: clear the three sums, then three accumulate cycles per accepted pair
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_cnt_d = clr_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        err_ovf_d = err_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = vec_len;
                    clr_cnt_d = 2'd0;
                    a_d       = '0;
                    b_d       = '0;
                    err_ovf_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == 2'd2) begin
                    clr_cnt_d = 2'd0;
                    state_d   = (cnt_q != '0) ? S_WAIT_IN : S_DONE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 2'd1;
                end
            end
            S_WAIT_IN: begin
                if (in_if.in_valid) begin
                    a_d     = in_if.a_data;
                    b_d     = in_if.b_data;
                    state_d = S_ACC_AB;
                end
            end
            S_ACC_AB: state_d = S_ACC_AA;
            S_ACC_AA: state_d = S_ACC_BB;
            S_ACC_BB: begin
                // count is non-zero here in normal operation; the guard keeps it from wrapping
                cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                state_d = (cnt_d != '0) ? S_WAIT_IN : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ovf) begin
            err_ovf_d = 1'b1;
        end
    end

    // State and holding registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clr_cnt_q <= 2'd0;
            a_q       <= '0;
            b_q       <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            err_ovf_q <= err_ovf_d;
        end
    end
endmodule

// File: tb/tb_cos_sim_accum_ctrl.sv
// tb/tb_cos_sim_accum_ctrl.sv - self-checking bench for cos_sim_accum_ctrl
module tb_cos_sim_accum_ctrl;
    localparam int         DATA_W  = 16;
    localparam int         LEN_W   = 10;
    localparam int         MAXN    = 8;
    localparam logic [2:0] REG_DOT = 3'd0;
    localparam logic [2:0] REG_AA  = 3'd1;
    localparam logic [2:0] REG_BB  = 3'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             rf_wr_en;
    logic [2:0]       rf_dest_reg;
    logic [31:0]      rf_wr_data;
    logic [2:0]       rf_src_1_addr;
    logic [2:0]       rf_src_2_addr;
    logic [31:0]      rf_src_1_data;
    logic             busy;
    logic             done;
    logic             err_ovf;

    logic [31:0] rf [8];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          viol;

    cos_sim_accum_ctrl_if #(.DATA_W(DATA_W)) s_if ();

    cos_sim_accum_ctrl #(
        .DATA_W(DATA_W), .LEN_W(LEN_W),
        .REG_DOT(REG_DOT), .REG_AA(REG_AA), .REG_BB(REG_BB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .vec_len(vec_len),
        .in_if(s_if),
        .rf_wr_en(rf_wr_en),
        .rf_dest_reg(rf_dest_reg),
        .rf_wr_data(rf_wr_data),
        .rf_src_1_addr(rf_src_1_addr),
        .rf_src_2_addr(rf_src_2_addr),
        .rf_src_1_data(rf_src_1_data),
        .busy(busy),
        .done(done),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // register file: one write port, combinational read
    assign rf_src_1_data = rf[rf_src_1_addr];
    always @(posedge clk) begin
        if (rf_wr_en) begin
            rf[rf_dest_reg] <= rf_wr_data;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    typedef struct packed {
        int                    n;
        logic [MAXN-1:0][15:0] a;
        logic [MAXN-1:0][15:0] b;
        logic [MAXN-1:0][3:0]  gap;
        int                    start_inj;
        logic [31:0]           r0;
        logic [31:0]           r1;
        logic [31:0]           r2;
        logic                  ovf;
        int                    done_cyc;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, ":ctl"}, 32'({s_if.in_ready, rf_wr_en, busy, done, err_ovf,
                               rf_dest_reg, rf_src_1_addr, rf_src_2_addr}), 32'd0);
        chk({nm, ":wr_data"}, rf_wr_data, 32'd0);
    endtask

    task automatic proto();
        if (rf_src_2_addr != 3'd0) viol++;
        if (rf_wr_en && (rf_src_1_addr != rf_dest_reg)) viol++;
        if (!rf_wr_en && (rf_dest_reg != 3'd0 || rf_src_1_addr != 3'd0 || rf_wr_data != 32'd0)) viol++;
        if ((s_if.in_ready || done) && !busy) viol++;
        if (s_if.in_ready && rf_wr_en) viol++;
    endtask

    // reference: exact integer sums, overflow when the true sum leaves the 32-bit signed range
    function automatic vec_t model(input vec_t vin);
        vec_t                v;
        longint              s [3];
        longint              p [3];
        longint              t;
        longint              ai;
        longint              bi;
        logic signed [31:0]  w;
        int                  gs;
        v  = vin;
        gs = 0;
        v.ovf = 1'b0;
        for (int k = 0; k < 3; k++) s[k] = 0;
        for (int i = 0; i < v.n; i++) begin
            ai = longint'($signed(v.a[i]));
            bi = longint'($signed(v.b[i]));
            p[0] = ai * bi;
            p[1] = ai * ai;
            p[2] = bi * bi;
            for (int k = 0; k < 3; k++) begin
                t = s[k] + p[k];
                if (t > 64'sd2147483647 || t < -64'sd2147483648) v.ovf = 1'b1;
                w = t[31:0];
                s[k] = w;
            end
            gs += int'(v.gap[i]);
        end
        v.r0 = s[0][31:0];
        v.r1 = s[1][31:0];
        v.r2 = s[2][31:0];
        v.done_cyc = 4 + 4 * v.n + gs;
        return v;
    endfunction

    function automatic vec_t base(input int n, input int dc, input logic [31:0] r0,
                                  input logic [31:0] r1, input logic [31:0] r2, input logic ovf);
        vec_t v;
        v = '0;
        v.n = n; v.done_cyc = dc; v.start_inj = -1;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.ovf = ovf;
        return v;
    endfunction

    function automatic vec_t c1();
        vec_t v;
        v = base(3, 16, 32'd32, 32'd14, 32'd77, 1'b0);
        v.a[0] = 16'd1; v.a[1] = 16'd2; v.a[2] = 16'd3;
        v.b[0] = 16'd4; v.b[1] = 16'd5; v.b[2] = 16'd6;
        return v;
    endfunction

    function automatic vec_t c5();
        vec_t v;
        v = base(2, 12, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
        v.a[0] = 16'h8000; v.a[1] = 16'h8000;
        v.b[0] = 16'h8000; v.b[1] = 16'h8000;
        return v;
    endfunction

    task automatic run_case(input vec_t v, input string nm);
        int   c, idx, gl, wr0, rdy, done_at, gsum;
        logic hs;
        viol = 0; rdy = 0; done_at = -1; idx = 0; hs = 1'b0;
        gl = int'(v.gap[0]);
        gsum = 0;
        for (int i = 0; i < v.n; i++) gsum += int'(v.gap[i]);
        wr0 = wr_cnt;
        vec_len = v.n[LEN_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        vec_len = LEN_W'($urandom);
        c = 1;
        while (done_at < 0 && c < v.done_cyc + 40) begin
            proto();
            if (s_if.in_ready) rdy++;
            if (done) begin
                done_at = c;
                if (s_if.in_ready || rf_wr_en) viol++;
            end else begin
                if (c == v.start_inj) begin
                    start = 1'b1;
                    vec_len = '0;
                end else begin
                    start = 1'b0;
                end
                hs = 1'b0;
                if (s_if.in_ready && idx < v.n) begin
                    if (gl > 0) begin
                        s_if.in_valid = 1'b0;
                        gl--;
                    end else begin
                        s_if.in_valid = 1'b1;
                        s_if.a_data = v.a[idx];
                        s_if.b_data = v.b[idx];
                        hs = 1'b1;
                    end
                end else begin
                    s_if.in_valid = 1'($urandom);
                    s_if.a_data = 16'($urandom);
                    s_if.b_data = 16'($urandom);
                end
                tick();
                if (hs) begin
                    idx++;
                    if (idx < v.n) gl = int'(v.gap[idx]);
                end
                c++;
            end
        end
        start = 1'b0;
        s_if.in_valid = 1'b0;
        chk({nm, ":done_cycle"}, 32'(done_at), 32'(v.done_cyc));
        tick();
        if (busy || done) viol++;
        chk({nm, ":r_dot"}, rf[REG_DOT], v.r0);
        chk({nm, ":r_aa"}, rf[REG_AA], v.r1);
        chk({nm, ":r_bb"}, rf[REG_BB], v.r2);
        chk({nm, ":err_ovf"}, 32'(err_ovf), 32'(v.ovf));
        chk({nm, ":writes"}, 32'(wr_cnt - wr0), 32'(3 + 3 * v.n));
        chk({nm, ":ready_cycles"}, 32'(rdy), 32'(v.n + gsum));
        chk({nm, ":protocol"}, 32'(viol), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   wr0;
        int   idx;

        rst = 1'b1; start = 1'b0; vec_len = '0;
        s_if.in_valid = 1'b0; s_if.a_data = '0; s_if.b_data = '0;

        tbl[0] = c1();
        tbl[1] = base(0, 4, 32'd0, 32'd0, 32'd0, 1'b0);
        tbl[2] = base(2, 12, 32'hFFFF_FFEA, 32'd13, 32'd41, 1'b0);
        tbl[2].a[0] = 16'hFFFD; tbl[2].a[1] = 16'd2;
        tbl[2].b[0] = 16'd4;    tbl[2].b[1] = 16'hFFFB;
        tbl[3] = c1();
        tbl[3].gap[1] = 4'd2; tbl[3].gap[2] = 4'd5; tbl[3].done_cyc = 23;
        tbl[4] = c5();
        tbl[5] = c1();
        tbl[6] = c1();
        tbl[6].start_inj = 6;
        tbl[7] = c5();

        tick();
        tick();
        zero_chk("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

        // sticky overflow from the last table entry must be dropped by reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        zero_chk("idle_reset");

        // reset during the second element's ACC_AB
        v = c1();
        vec_len = 10'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 9; c++) begin
            idx = (c >= 4) ? (c - 4) / 4 : 0;
            s_if.in_valid = 1'b1;
            s_if.a_data = v.a[idx];
            s_if.b_data = v.b[idx];
            tick();
        end
        chk("midrst:pre_write", 32'({rf_wr_en, rf_dest_reg}), 32'({1'b1, REG_DOT}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        zero_chk("midrst");
        wr0 = wr_cnt;
        repeat (10) tick();
        chk("midrst:no_writes", 32'(wr_cnt - wr0), 32'd0);
        zero_chk("midrst_idle");
        s_if.in_valid = 1'b0;
        tick();
        run_case(c1(), "after_reset");

        for (int r = 0; r < 40; r++) begin
            v = '0;
            v.n = $urandom_range(0, MAXN);
            for (int i = 0; i < MAXN; i++) begin
                if (r % 3 == 0) begin
                    v.a[i] = 16'($urandom);
                    v.b[i] = 16'($urandom);
                end else begin
                    v.a[i] = 16'($urandom_range(0, 200)) - 16'd100;
                    v.b[i] = 16'($urandom_range(0, 200)) - 16'd100;
                end
                v.gap[i] = 4'($urandom_range(0, 3));
            end
            v.start_inj = -1;
            v = model(v);
            if ($urandom_range(0, 1) == 1) v.start_inj = $urandom_range(1, v.done_cyc - 1);
            run_case(v, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
